// File: rtl/ntps_pkg.sv
// Shared definitions for NTP time selection and its status registers.
package ntps_pkg;

  localparam int unsigned NTP_TIME_WIDTH = 64;

  // active_src encodings, also used by the status register block
  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_A    = 2'b01;
  localparam logic [1:0] SRC_B    = 2'b10;

  // Selector states share the active_src encoding
  typedef enum logic [1:0] {
    ST_NONE  = SRC_NONE,
    ST_USE_A = SRC_A,
    ST_USE_B = SRC_B
  } sel_state_t;

  // One time source as seen by the selector
  typedef struct packed {
    logic [NTP_TIME_WIDTH-1:0] ntp_time;
    logic                      upd;
    logic                      sync_ok;
  } ntp_src_t;

endpackage

// File: rtl/ntp_src_monitor.sv
// Per-source health: update watchdog plus lock indication.
module ntp_src_monitor #(
  parameter int unsigned TIMEOUT_CYCLES = 250000000
) (
  input  logic axi_aclk,
  input  logic axi_aresetn,
  input  logic upd,
  input  logic sync_ok,
  output logic healthy_c
);

  localparam int unsigned    WD_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_q;

  // Cycles since last strobe; starts saturated so a source is stale until it strobes
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wd_q <= WD_MAX;
    end else if (upd) begin
      wd_q <= '0;
    end else if (wd_q < WD_MAX) begin
      wd_q <= wd_q + WD_W'(1);
    end
  end

  assign healthy_c = sync_ok && (wd_q < WD_MAX);

endmodule

// File: rtl/ntp_time_select.sv
// Selects one of two NTP time sources with health-driven failover and optional revert.
module ntp_time_select
  import ntps_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 250000000,
  parameter int unsigned HOLDOFF_CYCLES = 1250000000,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      axi_aclk,
  input  logic                      axi_aresetn,
  input  logic                      cfg_primary_b,
  input  logic                      cfg_revertive,
  input  logic [NTP_TIME_WIDTH-1:0] ntp_time_a,
  input  logic                      ntp_time_upd_a,
  input  logic                      sync_ok_a,
  input  logic [NTP_TIME_WIDTH-1:0] ntp_time_b,
  input  logic                      ntp_time_upd_b,
  input  logic                      sync_ok_b,
  output logic [NTP_TIME_WIDTH-1:0] ntp_time,
  output logic                      ntp_time_upd,
  output logic [1:0]                active_src,
  output logic [CNT_WIDTH-1:0]      failover_count,
  output logic                      time_step_back
);

  localparam int unsigned    HO_W   = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [HO_W-1:0] HO_MAX = HO_W'(HOLDOFF_CYCLES);

  ntp_src_t   src_a, src_b;
  sel_state_t state_q, state_d;
  logic       healthy_a, healthy_b;
  logic       fail_inc;
  logic       primary_b_q;
  logic [HO_W-1:0] holdoff_q;
  logic       holdoff_done;
  logic       valid_q;

  sel_state_t pri_st, oth_st, alt_st;
  logic       pri_ok, oth_ok, cur_ok, alt_ok;
  logic       fwd;
  logic [NTP_TIME_WIDTH-1:0] fwd_time;

  assign src_a = '{ntp_time: ntp_time_a, upd: ntp_time_upd_a, sync_ok: sync_ok_a};
  assign src_b = '{ntp_time: ntp_time_b, upd: ntp_time_upd_b, sync_ok: sync_ok_b};

  ntp_src_monitor #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_mon_a (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .upd(src_a.upd), .sync_ok(src_a.sync_ok), .healthy_c(healthy_a)
  );

  ntp_src_monitor #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_mon_b (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .upd(src_b.upd), .sync_ok(src_b.sync_ok), .healthy_c(healthy_b)
  );

  // Primary/other and current/alternate views of the two sources
  assign pri_st = cfg_primary_b ? ST_USE_B : ST_USE_A;
  assign oth_st = cfg_primary_b ? ST_USE_A : ST_USE_B;
  assign pri_ok = cfg_primary_b ? healthy_b : healthy_a;
  assign oth_ok = cfg_primary_b ? healthy_a : healthy_b;
  assign cur_ok = (state_q == ST_USE_A) ? healthy_a : healthy_b;
  assign alt_st = (state_q == ST_USE_A) ? ST_USE_B : ST_USE_A;
  assign alt_ok = (state_q == ST_USE_A) ? healthy_b : healthy_a;
  assign holdoff_done = (holdoff_q == HO_MAX);

  // Selector state register
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) state_q <= ST_NONE;
    else              state_q <= state_d;
  end

  // Next-state: failover has priority over revert; revert also needs the primary healthy now
  always_comb begin
    state_d  = state_q;
    fail_inc = 1'b0;
    case (state_q)
      ST_NONE: begin
        if (pri_ok)      state_d = pri_st;
        else if (oth_ok) state_d = oth_st;
      end
      ST_USE_A, ST_USE_B: begin
        if (!cur_ok) begin
          if (alt_ok) begin
            state_d  = alt_st;
            fail_inc = 1'b1;
          end else begin
            state_d = ST_NONE;
          end
        end else if ((state_q != pri_st) && cfg_revertive && holdoff_done && pri_ok) begin
          state_d = pri_st;
        end
      end
      default: state_d = ST_NONE;
    endcase
  end

  // Revert hold-off: counts continuous primary health while off-primary
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      holdoff_q   <= '0;
      primary_b_q <= 1'b0;
    end else begin
      primary_b_q <= cfg_primary_b;
      if (!pri_ok || (state_q == pri_st) || (cfg_primary_b != primary_b_q)) begin
        holdoff_q <= '0;
      end else if (!holdoff_done) begin
        holdoff_q <= holdoff_q + HO_W'(1);
      end
    end
  end

  // Saturating count of health-driven switches
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      failover_count <= '0;
    end else if (fail_inc && (failover_count != '1)) begin
      failover_count <= failover_count + CNT_WIDTH'(1);
    end
  end

  assign fwd      = ((state_q == ST_USE_A) && src_a.upd) || ((state_q == ST_USE_B) && src_b.upd);
  assign fwd_time = (state_q == ST_USE_A) ? src_a.ntp_time : src_b.ntp_time;

  // Forward strobes of the currently selected source and flag backward steps
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      ntp_time       <= '0;
      ntp_time_upd   <= 1'b0;
      time_step_back <= 1'b0;
      valid_q        <= 1'b0;
    end else if (fwd) begin
      ntp_time       <= fwd_time;
      ntp_time_upd   <= 1'b1;
      time_step_back <= valid_q && (fwd_time < ntp_time);
      valid_q        <= 1'b1;
    end else begin
      ntp_time_upd   <= 1'b0;
      time_step_back <= 1'b0;
    end
  end

  assign active_src = state_q;

endmodule

// File: tb/tb_ntp_time_select.sv
// Scoreboard bench for ntp_time_select with short timeout/hold-off.
module tb_ntp_time_select;

  localparam int unsigned TO = 16;
  localparam int unsigned HO = 32;

  logic        axi_aclk = 1'b0;
  logic        axi_aresetn = 1'b0;
  logic        cfg_primary_b = 1'b0, cfg_revertive = 1'b0;
  logic [63:0] ntp_time_a = '0, ntp_time_b = '0;
  logic        ntp_time_upd_a = 1'b0, ntp_time_upd_b = 1'b0;
  logic        sync_ok_a = 1'b0, sync_ok_b = 1'b0;
  logic [63:0] ntp_time;
  logic        ntp_time_upd;
  logic [1:0]  active_src;
  logic [15:0] failover_count;
  logic        time_step_back;

  ntp_time_select #(.TIMEOUT_CYCLES(TO), .HOLDOFF_CYCLES(HO), .CNT_WIDTH(16)) dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .cfg_primary_b(cfg_primary_b), .cfg_revertive(cfg_revertive),
    .ntp_time_a(ntp_time_a), .ntp_time_upd_a(ntp_time_upd_a), .sync_ok_a(sync_ok_a),
    .ntp_time_b(ntp_time_b), .ntp_time_upd_b(ntp_time_upd_b), .sync_ok_b(sync_ok_b),
    .ntp_time(ntp_time), .ntp_time_upd(ntp_time_upd), .active_src(active_src),
    .failover_count(failover_count), .time_step_back(time_step_back)
  );

  always #5 axi_aclk = ~axi_aclk;

  typedef struct {
    logic [63:0] t;
    logic        upd;
    logic [1:0]  act;
    logic [15:0] cnt;
    logic        step;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  int          m_wd_a, m_wd_b, m_state, m_hold;
  logic [15:0] m_cnt;
  logic [63:0] m_time;
  bit          m_valid, m_prim_q;

  // Stimulus generators
  bit          gen_a = 0, gen_b = 0;
  logic [63:0] t_a = 64'h0000_0100_0000_0000, t_b = 64'h0000_0100_0000_8000;
  logic [63:0] inc_b = 64'h1_0000_0000;
  logic [63:0] last_b = '0;
  int          phase = 0;
  bit          seen_step, seen_upd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wd_a = TO; m_wd_b = TO; m_state = 0; m_hold = 0;
    m_cnt = '0; m_time = '0; m_valid = 0; m_prim_q = 0;
    sb.delete();
  endtask

  // Expected outputs after the coming clock edge, from the inputs now applied
  task automatic model_step();
    bit ha, hb, hp, hc, ho, inc, fwd;
    int pri, ns, oth;
    logic [63:0] v;
    exp_t e;
    ha  = sync_ok_a && (m_wd_a < TO);
    hb  = sync_ok_b && (m_wd_b < TO);
    pri = cfg_primary_b ? 2 : 1;
    hp  = (pri == 1) ? ha : hb;
    inc = 0;
    ns  = m_state;
    if (m_state == 0) begin
      if (hp) ns = pri;
      else if ((pri == 1) ? hb : ha) ns = 3 - pri;
    end else begin
      oth = 3 - m_state;
      hc  = (m_state == 1) ? ha : hb;
      ho  = (oth == 1) ? ha : hb;
      if (!hc) begin
        if (ho) begin ns = oth; inc = 1; end
        else ns = 0;
      end else if (m_state != pri && cfg_revertive && m_hold >= int'(HO) && hp) begin
        ns = pri;
      end
    end
    if (!hp || m_state == pri || cfg_primary_b != m_prim_q) m_hold = 0;
    else if (m_hold < int'(HO)) m_hold++;
    m_prim_q = cfg_primary_b;
    fwd = (m_state == 1 && ntp_time_upd_a) || (m_state == 2 && ntp_time_upd_b);
    v   = (m_state == 1) ? ntp_time_a : ntp_time_b;
    e.upd = fwd;
    e.step = 0;
    if (fwd) begin
      e.step  = m_valid && (v < m_time);
      m_time  = v;
      m_valid = 1;
    end
    m_wd_a = ntp_time_upd_a ? 0 : ((m_wd_a < int'(TO)) ? m_wd_a + 1 : m_wd_a);
    m_wd_b = ntp_time_upd_b ? 0 : ((m_wd_b < int'(TO)) ? m_wd_b + 1 : m_wd_b);
    if (inc && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    m_state = ns;
    e.t = m_time; e.act = 2'(ns); e.cnt = m_cnt;
    sb.push_back(e);
  endtask

  // One clock: generate strobes, predict, then compare after the edge
  task automatic cycle();
    exp_t e;
    if (gen_a) begin
      ntp_time_upd_a = (phase % 8 == 0);
      if (ntp_time_upd_a) begin ntp_time_a = t_a; t_a += 64'h1_0000_0000; end
    end
    if (gen_b) begin
      ntp_time_upd_b = (phase % 8 == 4);
      if (ntp_time_upd_b) begin ntp_time_b = t_b; last_b = t_b; t_b += inc_b; end
    end
    phase++;
    model_step();
    @(posedge axi_aclk);
    #1;
    e = sb.pop_front();
    check("ntp_time", ntp_time, e.t);
    check("ntp_time_upd", 64'(ntp_time_upd), 64'(e.upd));
    check("active_src", 64'(active_src), 64'(e.act));
    check("failover_count", 64'(failover_count), 64'(e.cnt));
    check("time_step_back", 64'(time_step_back), 64'(e.step));
    if (time_step_back) seen_step = 1;
    if (ntp_time_upd) seen_upd = 1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_time"}, ntp_time, 64'h0);
    check({tag, "_upd"}, 64'(ntp_time_upd), 64'h0);
    check({tag, "_active"}, 64'(active_src), 64'h0);
    check({tag, "_count"}, 64'(failover_count), 64'h0);
    check({tag, "_step"}, 64'(time_step_back), 64'h0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge axi_aclk);
    #1;
    check_zero("reset");
    axi_aresetn = 1'b1;

    // Both sources up, A primary
    sync_ok_a = 1; sync_ok_b = 1; gen_a = 1; gen_b = 1;
    run(40);
    check("start_active_a", 64'(active_src), 64'h1);

    // A stops strobing: fail over to B
    gen_a = 0; ntp_time_upd_a = 0;
    run(30);
    check("failover_active_b", 64'(active_src), 64'h2);
    check("failover_count1", 64'(failover_count), 64'h1);
    check("follows_b", ntp_time, last_b);

    // A returns, non-revertive: stays on B
    gen_a = 1;
    run(80);
    check("nonrevert_stays_b", 64'(active_src), 64'h2);

    // Revertive: returns to A without counting
    cfg_revertive = 1;
    run(60);
    check("revert_active_a", 64'(active_src), 64'h1);
    check("revert_count1", 64'(failover_count), 64'h1);

    // Latency: a single A strobe appears next cycle for exactly one cycle
    gen_a = 0; ntp_time_upd_a = 0;
    ntp_time_a = 64'h0000_0001_8000_0000; ntp_time_upd_a = 1;
    cycle();
    ntp_time_upd_a = 0;
    check("latency_time", ntp_time, 64'h0000_0001_8000_0000);
    check("latency_upd", 64'(ntp_time_upd), 64'h1);
    cycle();
    check("latency_upd_drop", 64'(ntp_time_upd), 64'h0);

    // Step back: A at 0x10_0000_0000, then B takes over with a smaller value
    t_b = 64'h0F_FFFF_0000; inc_b = '0;
    ntp_time_a = 64'h10_0000_0000; ntp_time_upd_a = 1;
    cycle();
    ntp_time_upd_a = 0;
    seen_step = 0;
    run(40);
    check("stepback_seen", 64'(seen_step), 64'h1);
    check("stepback_active_b", 64'(active_src), 64'h2);
    check("stepback_count2", 64'(failover_count), 64'h2);

    // Both sources lost in the same cycle
    sync_ok_a = 0; sync_ok_b = 0;
    cycle();
    check("lost_active_none", 64'(active_src), 64'h0);
    check("lost_count2", 64'(failover_count), 64'h2);
    seen_upd = 0;
    run(20);
    check("lost_no_upd", 64'(seen_upd), 64'h0);
    check("lost_time_held", ntp_time, 64'h0F_FFFF_0000);

    // Primary changed while in NONE; recovery selects B
    cfg_primary_b = 1; sync_ok_a = 1; sync_ok_b = 1; gen_a = 1;
    run(30);
    check("recover_active_b", 64'(active_src), 64'h2);
    check("recover_count2", 64'(failover_count), 64'h2);

    // Asynchronous reset mid-operation
    axi_aresetn = 1'b0;
    #1;
    check_zero("midreset");
    model_reset();
    repeat (2) @(posedge axi_aclk);
    #1;
    axi_aresetn = 1'b1;
    gen_a = 0; gen_b = 0; ntp_time_upd_a = 0; ntp_time_upd_b = 0;
    run(10);
    check("post_reset_none", 64'(active_src), 64'h0);
    gen_b = 1; inc_b = 64'h1_0000_0000;
    run(20);
    check("post_reset_b", 64'(active_src), 64'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
